// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//   Iterative RV32M multiply/divide unit for the execute stage. Multiplies with
//   a radix-2 shift-add loop and divides with a restoring loop. Both loops work
//   on operand magnitudes, and the sign is fixed up when the loop finishes.
//   Divide-by-zero and signed overflow bypass the loop and complete in one
//   cycle.
//
// Ports
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset
//   start    : operation request, sampled only while idle
//   flush    : abort any in-flight operation (pipeline redirect)
//   a, b     : rs1 / rs2 operands
//   sel      : 0 mul low, 1 mul high, 2 quotient, 3 remainder
//   su_op1   : multiply only, a is signed
//   su_op2   : multiply only, b is signed
//   divsign  : div/rem only, both operands are signed
//   busy     : high whenever the unit is not idle
//   done     : one-cycle pulse, result valid in that cycle
//   result   : registered result, held until the next accepted start
// -----------------------------------------------------------------------------
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             flush,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       sel,
  input  logic             su_op1,
  input  logic             su_op2,
  input  logic             divsign,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam logic [1:0] SEL_MUL_L = 2'd0;
  localparam logic [1:0] SEL_MUL_U = 2'd1;
  localparam logic [1:0] SEL_DIV   = 2'd2;
  localparam logic [1:0] SEL_REM   = 2'd3;

  localparam logic [WIDTH-1:0]   ZERO_W   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0]   ONES_W   = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0]   ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]   MIN_W    = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [2*WIDTH-1:0] ZERO_2W  = {(2*WIDTH){1'b0}};
  localparam logic [2*WIDTH-1:0] ONE_2W   = {{(2*WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH:0]     ZERO_W1  = {(WIDTH+1){1'b0}};
  localparam logic [5:0]         LAST_CNT = 6'(WIDTH-1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Two's-complement magnitude of v when it is treated as signed and negative.
  function automatic logic [WIDTH-1:0] mag_of(input logic [WIDTH-1:0] v,
                                              input logic             is_signed);
    if (is_signed && v[WIDTH-1]) begin
      mag_of = ~v + ONE_W;
    end else begin
      mag_of = v;
    end
  endfunction

  // Conditional WIDTH-bit two's-complement negate.
  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v,
                                             input logic             do_neg);
    if (do_neg) begin
      neg_w = ~v + ONE_W;
    end else begin
      neg_w = v;
    end
  endfunction

  // Conditional 2*WIDTH-bit two's-complement negate (full product).
  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v,
                                                input logic               do_neg);
    if (do_neg) begin
      neg_2w = ~v + ONE_2W;
    end else begin
      neg_2w = v;
    end
  endfunction

  state_t             state_r;
  state_t             next_state_s;
  logic [5:0]         cnt_r;
  logic [2*WIDTH-1:0] acc_r;
  logic [WIDTH-1:0]   op_a_r;     // multiplicand, or dividend shifting out MSB-first
  logic [WIDTH-1:0]   op_b_r;     // multiplier shifting out LSB-first, or divisor
  logic [1:0]         sel_r;
  logic               neg_res_r;
  logic [WIDTH-1:0]   result_r;
  logic               done_r;
  logic               busy_r;

  logic               accept_s;
  logic               is_div_s;
  logic               a_sgn_en_s;
  logic               b_sgn_en_s;
  logic               neg_res_in_s;
  logic               div_zero_s;
  logic               div_ovf_s;
  logic               fast_s;
  logic [WIDTH-1:0]   fast_result_s;
  logic [WIDTH:0]     mul_sum_s;
  logic [WIDTH:0]     div_shift_s;
  logic [WIDTH-1:0]   div_diff_s;
  logic               div_ge_s;
  logic [WIDTH-1:0]   div_rem_nxt_s;
  logic [2*WIDTH-1:0] acc_step_s;
  logic [2*WIDTH-1:0] prod_final_s;
  logic [WIDTH-1:0]   final_result_s;
  logic               last_iter_s;

  assign busy   = busy_r;
  assign done   = done_r;
  assign result = result_r;

  // Operand decode at accept: signedness, result sign and fast-path detection.
  always_comb begin
    is_div_s      = sel[1];
    accept_s      = (state_r == S_IDLE) && start && !flush;
    a_sgn_en_s    = is_div_s ? divsign : su_op1;
    b_sgn_en_s    = is_div_s ? divsign : su_op2;
    neg_res_in_s  = 1'b0;
    fast_result_s = ZERO_W;
    case (sel)
      SEL_MUL_L, SEL_MUL_U: neg_res_in_s = (a[WIDTH-1] & su_op1) ^ (b[WIDTH-1] & su_op2);
      SEL_DIV:              neg_res_in_s = (a[WIDTH-1] ^ b[WIDTH-1]) & divsign;
      SEL_REM:              neg_res_in_s = a[WIDTH-1] & divsign;
      default:              neg_res_in_s = 1'b0;
    endcase
    div_zero_s = is_div_s && (b == ZERO_W);
    div_ovf_s  = is_div_s && divsign && (a == MIN_W) && (b == ONES_W);
    fast_s     = div_zero_s || div_ovf_s;
    // Divide-by-zero takes priority; the overflow case has b != 0 anyway.
    if (div_zero_s) begin
      fast_result_s = (sel == SEL_DIV) ? ONES_W : a;
    end else if (div_ovf_s) begin
      fast_result_s = (sel == SEL_DIV) ? MIN_W : ZERO_W;
    end else begin
      fast_result_s = ZERO_W;
    end
  end

  // One iteration of the multiply or divide loop, plus final sign fix-up.
  always_comb begin
    // Multiply: add multiplicand into the upper half, then shift right by one.
    if (op_b_r[0]) begin
      mul_sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, op_a_r};
    end else begin
      mul_sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + ZERO_W1;
    end
    // Divide: bring the next dividend bit into the partial remainder and
    // trial-subtract. The difference fits in WIDTH bits whenever it is kept.
    div_shift_s   = {acc_r[2*WIDTH-1:WIDTH], op_a_r[WIDTH-1]};
    div_ge_s      = (div_shift_s >= {1'b0, op_b_r});
    div_diff_s    = div_shift_s[WIDTH-1:0] - op_b_r;
    if (div_ge_s) begin
      div_rem_nxt_s = div_diff_s;
    end else begin
      div_rem_nxt_s = div_shift_s[WIDTH-1:0];
    end
    if (sel_r[1]) begin
      acc_step_s = {div_rem_nxt_s, acc_r[WIDTH-2:0], div_ge_s};
    end else begin
      acc_step_s = {mul_sum_s, acc_r[WIDTH-1:1]};
    end
    last_iter_s  = (cnt_r == LAST_CNT);
    prod_final_s = neg_2w(acc_step_s, neg_res_r);
    case (sel_r)
      SEL_MUL_L: final_result_s = prod_final_s[WIDTH-1:0];
      SEL_MUL_U: final_result_s = prod_final_s[2*WIDTH-1:WIDTH];
      SEL_DIV:   final_result_s = neg_w(acc_step_s[WIDTH-1:0], neg_res_r);
      SEL_REM:   final_result_s = neg_w(acc_step_s[2*WIDTH-1:WIDTH], neg_res_r);
      default:   final_result_s = ZERO_W;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state logic; flush beats start and aborts any state.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (flush) begin
          next_state_s = S_IDLE;
        end else if (start && fast_s) begin
          next_state_s = S_DONE;
        end else if (start) begin
          next_state_s = S_CALC;
        end else begin
          next_state_s = S_IDLE;
        end
      end
      S_CALC: begin
        if (flush) begin
          next_state_s = S_IDLE;
        end else if (last_iter_s) begin
          next_state_s = S_DONE;
        end else begin
          next_state_s = S_CALC;
        end
      end
      S_DONE:  next_state_s = S_IDLE;
      default: next_state_s = S_IDLE;
    endcase
  end

  // Datapath registers and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r     <= 6'd0;
      acc_r     <= ZERO_2W;
      op_a_r    <= ZERO_W;
      op_b_r    <= ZERO_W;
      sel_r     <= 2'd0;
      neg_res_r <= 1'b0;
      result_r  <= ZERO_W;
      done_r    <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      busy_r <= (next_state_s != S_IDLE);
      done_r <= (next_state_s == S_DONE);
      case (state_r)
        S_IDLE: begin
          if (accept_s) begin
            sel_r     <= sel;
            neg_res_r <= neg_res_in_s;
            op_a_r    <= mag_of(a, a_sgn_en_s);
            op_b_r    <= mag_of(b, b_sgn_en_s);
            acc_r     <= ZERO_2W;
            cnt_r     <= 6'd0;
            if (fast_s) begin
              result_r <= fast_result_s;
            end
          end
        end
        S_CALC: begin
          if (!flush) begin
            acc_r <= acc_step_s;
            cnt_r <= cnt_r + 6'd1;
            if (sel_r[1]) begin
              op_a_r <= {op_a_r[WIDTH-2:0], 1'b0};
            end else begin
              op_b_r <= {1'b0, op_b_r[WIDTH-1:1]};
            end
            if (last_iter_s) begin
              result_r <= final_result_s;
            end
          end
        end
        S_DONE: begin
          cnt_r <= cnt_r;
        end
        default: begin
          cnt_r <= 6'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
//   Directed self-checking bench for muldiv_unit with hand-computed vectors.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic        flush;
  logic [31:0] a;
  logic [31:0] b;
  logic [1:0]  sel;
  logic        su_op1;
  logic        su_op2;
  logic        divsign;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_checks;
  int n_errors;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .flush   (flush),
    .a       (a),
    .b       (b),
    .sel     (sel),
    .su_op1  (su_op1),
    .su_op2  (su_op2),
    .divsign (divsign),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one operation in cycle 0 and check latency, result and the pulse shape.
  task automatic run_op(input string tag, input logic [1:0] s, input logic [31:0] av,
                        input logic [31:0] bv, input logic s1, input logic s2,
                        input logic ds, input logic [31:0] exp_res, input int exp_lat);
    int cyc;
    @(posedge clk); #1;
    a = av; b = bv; sel = s; su_op1 = s1; su_op2 = s2; divsign = ds; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    check_eq({tag, "_busy1"}, 32'(busy), 32'd1);
    while (!done && cyc < 60) begin
      @(posedge clk); #1;
      cyc = cyc + 1;
    end
    check_eq({tag, "_done"}, 32'(done), 32'd1);
    check_eq({tag, "_lat"}, 32'(cyc), 32'(exp_lat));
    check_eq({tag, "_res"}, result, exp_res);
    @(posedge clk); #1;
    check_eq({tag, "_done_lo"}, 32'(done), 32'd0);
    check_eq({tag, "_busy_lo"}, 32'(busy), 32'd0);
    check_eq({tag, "_hold"}, result, exp_res);
  endtask

  initial begin
    int n_done;
    int done_cyc;
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1; start = 1'b0; flush = 1'b0;
    a = 32'd0; b = 32'd0; sel = 2'd0; su_op1 = 1'b0; su_op2 = 1'b0; divsign = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_result", result, 32'd0);
    rst = 1'b0;

    // Multiply, all sign combinations of 0xFFFFFFFF * 2.
    run_op("mull_ss", 2'd0, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFE, 33);
    run_op("mulu_ss", 2'd1, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF, 33);
    run_op("mulu_uu", 2'd1, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 1'b0, 1'b0, 32'h0000_0001, 33);
    run_op("mulu_su", 2'd1, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 33);
    run_op("mull_uu", 2'd0, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFE, 33);
    run_op("mulu_us", 2'd1, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 33);
    // (-3) * (-5) = 15
    run_op("mull_nn", 2'd0, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 1'b1, 1'b1, 1'b0, 32'h0000_000F, 33);
    run_op("mulu_nn", 2'd1, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 1'b1, 1'b1, 1'b0, 32'h0000_0000, 33);
    // 2^16 * 2^16 = 2^32
    run_op("mulu_big", 2'd1, 32'h0001_0000, 32'h0001_0000, 1'b0, 1'b0, 1'b0, 32'h0000_0001, 33);

    // Divide / remainder.
    run_op("div_s",  2'd2, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFD, 33);
    run_op("rem_s",  2'd3, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 33);
    run_op("div_u",  2'd2, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 1'b0, 1'b0, 32'h7FFF_FFFC, 33);
    run_op("rem_u",  2'd3, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 1'b0, 1'b0, 32'h0000_0001, 33);
    // 100 / -7 = -14 rem 2
    run_op("div_pn", 2'd2, 32'd100, 32'hFFFF_FFF9, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFF2, 33);
    run_op("rem_pn", 2'd3, 32'd100, 32'hFFFF_FFF9, 1'b0, 1'b0, 1'b1, 32'h0000_0002, 33);

    // Fast paths.
    run_op("div_z",   2'd2, 32'd7, 32'd0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 1);
    run_op("rem_z",   2'd3, 32'd7, 32'd0, 1'b0, 1'b0, 1'b0, 32'h0000_0007, 1);
    run_op("rem_zs",  2'd3, 32'hFFFF_FFF9, 32'd0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFF9, 1);
    run_op("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 1);
    run_op("rem_ovf", 2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 1);
    run_op("div_z2",  2'd2, 32'd7, 32'd0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 1);

    // Flush at cycle 10 of a multiply: no done, result keeps 0xFFFFFFFF.
    @(posedge clk); #1;
    a = 32'd3; b = 32'd5; sel = 2'd0; su_op1 = 1'b0; su_op2 = 1'b0; divsign = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check_eq("flush_busy", 32'(busy), 32'd0);
    check_eq("flush_done", 32'(done), 32'd0);
    check_eq("flush_result", result, 32'hFFFF_FFFF);
    n_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) n_done = n_done + 1;
    end
    check_eq("flush_no_done", 32'(n_done), 32'd0);

    // Flush and start together: flush wins.
    @(posedge clk); #1;
    start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    check_eq("flush_start_busy", 32'(busy), 32'd0);
    check_eq("flush_start_done", 32'(done), 32'd0);
    run_op("after_flush", 2'd0, 32'd3, 32'd5, 1'b0, 1'b0, 1'b0, 32'h0000_000F, 33);

    // Start held high: accepts at cycle 0 and 34; reset at cycle 20 of the second.
    @(posedge clk); #1;
    a = 32'd6; b = 32'd7; sel = 2'd0; su_op1 = 1'b0; su_op2 = 1'b0; divsign = 1'b0;
    start = 1'b1;
    n_done = 0;
    done_cyc = 0;
    for (int cyc = 1; cyc <= 54; cyc++) begin
      @(posedge clk); #1;
      if (done) begin
        n_done = n_done + 1;
        done_cyc = cyc;
        check_eq("held_result", result, 32'd42);
      end
      if (cyc == 34) check_eq("held_busy_gap", 32'(busy), 32'd0);
      if (cyc == 35) check_eq("held_busy_reaccept", 32'(busy), 32'd1);
      if (cyc == 54) rst = 1'b1;
    end
    check_eq("held_n_done", 32'(n_done), 32'd1);
    check_eq("held_done_cyc", 32'(done_cyc), 32'd33);
    @(posedge clk); #1;
    rst = 1'b0;
    start = 1'b0;
    check_eq("midrst_busy", 32'(busy), 32'd0);
    check_eq("midrst_done", 32'(done), 32'd0);
    check_eq("midrst_result", result, 32'd0);
    n_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) n_done = n_done + 1;
    end
    check_eq("midrst_no_done", 32'(n_done), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
